// File: rtl/parking_pkg.sv
// Shared types and the sensor-pattern table for the parking sensor emulator.
// Sensor a is the outer beam, b the inner beam; {a,b} walks one bit at a time.
package parking_pkg;

  typedef enum logic [1:0] {ENTER, EXIT, ENTER_BALK, EXIT_BALK} cmd_kind_t;
  typedef enum logic [2:0] {IDLE, P1, P2, P3, GAP} state_t;

  localparam logic BLOCKED = 1'b1;
  localparam logic OPEN    = 1'b0;

  function automatic logic [1:0] pattern(cmd_kind_t kind, state_t st);
    logic [1:0] ab;
    ab = {OPEN, OPEN};
    case (st)
      P1: ab = (kind == ENTER || kind == ENTER_BALK) ? {BLOCKED, OPEN} : {OPEN, BLOCKED};
      P2: ab = {BLOCKED, BLOCKED};
      // Balks back out through the sensor they came in on.
      P3: ab = (kind == ENTER || kind == EXIT_BALK) ? {OPEN, BLOCKED} : {BLOCKED, OPEN};
      default: ab = {OPEN, OPEN};
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase dwell timer: loadable down-counter that parks at zero.
module phase_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expired
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/parking_sensor_emulator.sv
// Turns accepted car commands into timed a/b photosensor blocking sequences.
//  state | meaning
//  IDLE  | both beams open, ready for a command
//  P1    | first beam blocked (outer for enter, inner for exit)
//  P2    | both beams blocked
//  P3    | car leaving the far beam, or backing out on a balk
//  GAP   | both beams open, spacing before the next pass
module parking_sensor_emulator
  import parking_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_kind,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nx;
  cmd_kind_t          kind_q, kind_nx;
  logic [DWELL_W-1:0] dm1_q, dm1_nx;
  logic [DWELL_W-1:0] dwell_m1;
  logic [DWELL_W-1:0] load_val;
  logic               load;
  logic               expired;
  logic               done_nx;
  logic [1:0]         ab_nx;

  // dwell of 0 behaves as 1, so the reload is max(dwell,1)-1.
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  phase_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_comb begin
    state_nx = state;
    kind_nx  = kind_q;
    dm1_nx   = dm1_q;
    load     = 1'b0;
    load_val = dm1_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = P1;
          kind_nx  = cmd_kind_t'(cmd_kind);
          dm1_nx   = dwell_m1;
          load     = 1'b1;
          load_val = dwell_m1;
        end
      end
      P1: if (expired) begin state_nx = P2;  load = 1'b1; end
      P2: if (expired) begin state_nx = P3;  load = 1'b1; end
      P3: if (expired) begin state_nx = GAP; load = 1'b1; end
      GAP: begin
        if (expired) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    ab_nx = pattern(kind_nx, state_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      kind_q <= ENTER;
      dm1_q  <= '0;
      a      <= OPEN;
      b      <= OPEN;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      kind_q <= kind_nx;
      dm1_q  <= dm1_nx;
      a      <= ab_nx[1];
      b      <= ab_nx[0];
      done   <= done_nx;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

endmodule

// File: tb/tb_parking_sensor_emulator.sv
// Self-checking bench: per-cycle waveform model plus a sequence-level enter/exit decoder.
module tb_parking_sensor_emulator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [7:0] dwell;
  logic       a, b, busy, done;

  always #5 clk = ~clk;

  parking_sensor_emulator #(.DWELL_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .dwell     (dwell),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {logic [1:0] ab; logic busy; logic done;} exp_t;

  // Phase patterns P1,P2,P3 per command kind; GAP and idle are 00.
  logic [1:0] pat [4][3] = '{'{2'b10, 2'b11, 2'b01},
                             '{2'b01, 2'b11, 2'b10},
                             '{2'b10, 2'b11, 2'b10},
                             '{2'b01, 2'b11, 2'b01}};

  exp_t       q[$];
  exp_t       cur;
  logic       m_ready;
  int         checks, failures;
  int         enters, exits, dones, accepts;
  int         exp_en, exp_ex;
  logic [1:0] hist[$];

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int d;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      cur = '0;
    end else begin
      if (m_ready && cmd_valid) begin
        d = (dwell == 0) ? 1 : int'(dwell);
        for (int ph = 0; ph < 3; ph++)
          for (int i = 0; i < d; i++) q.push_back({pat[cmd_kind][ph], 1'b1, 1'b0});
        for (int i = 0; i < d; i++) q.push_back({2'b00, 1'b1, 1'b0});
        q.push_back({2'b00, 1'b0, 1'b1});
        accepts++;
      end
      cur = (q.size() > 0) ? q.pop_front() : exp_t'('0);
    end
    m_ready = ~cur.busy;
    #1;
    chk("ab", {14'd0, a, b}, {14'd0, cur.ab});
    chk("busy", {15'd0, busy}, {15'd0, cur.busy});
    chk("done", {15'd0, done}, {15'd0, cur.done});
    chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, ~cur.busy});
    if (done) dones++;
    // Decode the distinct non-00 steps of each pass, as the occupancy FSM would.
    if ({a, b} == 2'b00) begin
      if (hist.size() == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b01) enters++;
      if (hist.size() == 3 && hist[0] == 2'b01 && hist[1] == 2'b11 && hist[2] == 2'b10) exits++;
      hist.delete();
    end else if (hist.size() == 0 || hist[$] != {a, b}) begin
      hist.push_back({a, b});
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (cur.busy && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", {15'd0, cur.busy}, 16'd0);
  endtask

  task automatic send(input logic [1:0] k, input logic [7:0] d);
    cmd_kind  = k;
    dwell     = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_kind  = 2'($urandom);
    dwell     = 8'($urandom);
    if (k == 2'd0) exp_en++;
    if (k == 2'd1) exp_ex++;
    wait_idle(1100);
  endtask

  initial begin
    int n, a0, d0, k, dw;
    checks = 0; failures = 0; enters = 0; exits = 0; dones = 0; accepts = 0;
    exp_en = 0; exp_ex = 0;
    cur = '0; m_ready = 1'b1;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 2'd0; dwell = 8'd0;
    #1;
    chk("reset_async_ab", {14'd0, a, b}, 16'd0);
    chk("reset_async_ready", {15'd0, cmd_ready}, 16'd1);
    tick();
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    repeat (2) tick();

    // Full enter and exit passes.
    send(2'd0, 8'd5);
    chk("enter_count_1", 16'(enters), 16'd1);
    chk("exit_count_1", 16'(exits), 16'd0);
    send(2'd1, 8'd5);
    chk("exit_count_2", 16'(exits), 16'd1);
    chk("enter_count_2", 16'(enters), 16'd1);

    // Balks: two done pulses, no decoded pass.
    d0 = dones;
    send(2'd2, 8'd3);
    send(2'd3, 8'd3);
    chk("balk_dones", 16'(dones - d0), 16'd2);
    chk("balk_enters", 16'(enters), 16'(exp_en));
    chk("balk_exits", 16'(exits), 16'(exp_ex));

    // Dwell extremes.
    send(2'd0, 8'd0);
    send(2'd0, 8'd255);
    chk("extreme_enters", 16'(enters), 16'(exp_en));

    // Command held valid: three back-to-back passes, each accepted in the previous done cycle.
    a0 = accepts;
    cmd_kind = 2'd0; dwell = 8'd4; cmd_valid = 1'b1;
    n = 0;
    while (accepts < a0 + 3 && n < 200) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accept_timeout", 16'(accepts - a0), 16'd3);
    exp_en += 3;
    wait_idle(100);
    chk("b2b_enters", 16'(enters), 16'(exp_en));

    // A valid pulse mid-sequence must be ignored.
    cmd_kind = 2'd0; dwell = 8'd6; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_en++;
    repeat (7) tick();
    cmd_kind = 2'd1; dwell = 8'd2; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle(100);
    repeat (3) tick();
    chk("ignore_enters", 16'(enters), 16'(exp_en));
    chk("ignore_exits", 16'(exits), 16'(exp_ex));

    // Asynchronous reset in P2 of an ENTER.
    d0 = dones;
    cmd_kind = 2'd0; dwell = 8'd5; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    chk("pre_reset_ab", {14'd0, a, b}, 16'h3);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_ab", {14'd0, a, b}, 16'd0);
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("async_rst_done", {15'd0, done}, 16'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_done", 16'(dones - d0), 16'd0);
    chk("abort_no_enter", 16'(enters), 16'(exp_en));
    send(2'd1, 8'd4);
    chk("post_reset_exit", 16'(exits), 16'(exp_ex));

    // Randomized commands against the model.
    for (int r = 0; r < 8; r++) begin
      k  = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 12));
      send(2'(k), 8'(dw));
      repeat (int'($urandom_range(0, 3))) tick();
    end
    chk("rand_enters", 16'(enters), 16'(exp_en));
    chk("rand_exits", 16'(exits), 16'(exp_ex));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
